// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter sharing one single-cycle-latency ALU among N_REQ
//   requesters. Each requester hands over instr/op1/op2 with a valid/ready
//   handshake. Its result comes back one cycle later on a per-requester
//   response channel, together with an illegal-opcode flag.
//
// Parameters
//   N_REQ  number of requesters (2..8)
//   TRACE  nonzero: print each grant in simulation (not in synthesis builds)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready        per-requester request handshake
//                                  (o_req_ready is one-hot)
//   i_req_instr/i_req_op1/i_req_op2  per-requester 32-bit slices [32*i +: 32]
//   o_rsp_valid/i_rsp_ready        per-requester response handshake
//                                  (at most one bit of o_rsp_valid is set)
//   o_rsp_result, o_rsp_illegal    shared response payload
//   o_alu_enable/o_alu_instr/o_alu_op1/o_alu_op2   drive the ALU
//   i_alu_instr_exec, i_alu_result                 returned by the ALU
//
// Optional feature (macro ALU_ARB_STATS_EN)
//   o_grant_count   N_REQ x 16-bit saturating grant counters
//   o_illegal_count 16-bit saturating count of accepted illegal responses
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned TRACE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    output logic [N_REQ-1:0]      o_req_ready,
    input  logic [N_REQ*32-1:0]   i_req_instr,
    input  logic [N_REQ*32-1:0]   i_req_op1,
    input  logic [N_REQ*32-1:0]   i_req_op2,
    output logic [N_REQ-1:0]      o_rsp_valid,
    input  logic [N_REQ-1:0]      i_rsp_ready,
    output logic [31:0]           o_rsp_result,
    output logic                  o_rsp_illegal,
`ifdef ALU_ARB_STATS_EN
    output logic [N_REQ*16-1:0]   o_grant_count,
    output logic [15:0]           o_illegal_count,
`endif
    output logic                  o_alu_enable,
    output logic [31:0]           o_alu_instr,
    output logic [31:0]           o_alu_op1,
    output logic [31:0]           o_alu_op2,
    input  logic                  i_alu_instr_exec,
    input  logic [31:0]           i_alu_result
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0] r_rr_ptr;
    logic          r_pend_valid;
    logic [IW-1:0] r_pend_idx;

    logic          w_slot_free;
    logic          w_any;
    logic          w_grant;
    logic [IW-1:0] w_winner;
    logic [IW-1:0] w_next_ptr;
    logic          w_rsp_accept;
    int unsigned   w_scan_idx;

    // The pending slot frees up in the same cycle its response is taken,
    // which is what allows one op per cycle.
    assign w_rsp_accept = r_pend_valid && i_rsp_ready[r_pend_idx];
    assign w_slot_free  = !r_pend_valid || i_rsp_ready[r_pend_idx];

    // Scan requesters starting at the round-robin pointer; first hit wins.
    always_comb begin
        w_any      = 1'b0;
        w_winner   = '0;
        w_scan_idx = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_scan_idx = 32'(r_rr_ptr) + k;
            if (w_scan_idx >= N_REQ) begin
                w_scan_idx = w_scan_idx - N_REQ;
            end
            if (!w_any && i_req_valid[IW'(w_scan_idx)]) begin
                w_any    = 1'b1;
                w_winner = IW'(w_scan_idx);
            end
        end
    end

    assign w_grant    = w_slot_free && w_any;
    assign w_next_ptr = (w_winner == IW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;

    assign o_req_ready  = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;
    assign o_alu_enable = w_grant;
    assign o_alu_instr  = w_grant ? i_req_instr[32*w_winner +: 32] : '0;
    assign o_alu_op1    = w_grant ? i_req_op1[32*w_winner +: 32]   : '0;
    assign o_alu_op2    = w_grant ? i_req_op2[32*w_winner +: 32]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
        end else if (w_grant) begin
            r_rr_ptr     <= w_next_ptr;
            r_pend_valid <= 1'b1;
            r_pend_idx   <= w_winner;
        end else begin
            r_pend_valid <= r_pend_valid && !i_rsp_ready[r_pend_idx];
        end
    end

    // The ALU keeps result/instr_exec stable while alu_enable is low, so the
    // response payload can be taken straight from it during a stall.
    assign o_rsp_valid   = r_pend_valid ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_pend_idx) : '0;
    assign o_rsp_result  = i_alu_result;
    assign o_rsp_illegal = r_pend_valid && !i_alu_instr_exec;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_grant_cnt [N_REQ];
    logic [15:0] r_illegal_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                r_grant_cnt[i] <= '0;
            end
            r_illegal_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (w_grant && (w_winner == IW'(i)) && (r_grant_cnt[i] != 16'hFFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
            if (w_rsp_accept && !i_alu_instr_exec && (r_illegal_cnt != 16'hFFFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_cnt_out
        assign o_grant_count[16*g +: 16] = r_grant_cnt[g];
    end
    assign o_illegal_count = r_illegal_cnt;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_rsp_accept;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (TRACE != 0 && !rst && w_grant) begin
            $display("alu_arbiter: grant req %0d instr %08h", w_winner, o_alu_instr);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one 2-requester and one 4-requester instance, each
// driving its own small ALU model (ADD=1, SUB=2, XOR=3, anything else is
// illegal and leaves the result untouched). A transaction-level model of the
// arbitration rules is checked against both instances every cycle; directed
// sequences add literal expectations for grant order and result values.
module tb_alu_arbiter;

    localparam logic [31:0] OP_ADD = 32'h1;
    localparam logic [31:0] OP_SUB = 32'h2;
    localparam logic [31:0] OP_BAD = 32'hDEAD;

    logic clk;
    logic rst;

    logic [3:0]   req_valid [2];
    logic [3:0]   rsp_ready [2];
    logic [127:0] req_instr [2];
    logic [127:0] req_op1   [2];
    logic [127:0] req_op2   [2];

    wire  [3:0]   req_ready [2];
    wire  [3:0]   rsp_valid [2];
    wire  [31:0]  rsp_result [2];
    wire          rsp_illegal [2];
    wire          alu_enable [2];
    wire  [31:0]  alu_instr [2];
    wire  [31:0]  alu_op1 [2];
    wire  [31:0]  alu_op2 [2];

    logic [31:0]  alu_res [2];
    logic         alu_exec [2];

`ifdef ALU_ARB_STATS_EN
    wire [31:0] gc0;
    wire [15:0] ic0;
    wire [63:0] gc1;
    wire [15:0] ic1;
`endif

    int errors = 0;
    int checks = 0;

    // Model state per instance
    int          m_ptr  [2];
    bit          m_pend [2];
    int          m_pidx [2];
    logic [31:0] m_last [2];
    logic [31:0] m_res  [2];
    bit          m_ill  [2];
    int          glog0 [$];
    int          glog1 [$];
    int          exp4 [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0};
    int          exp2 [4]  = '{0, 1, 0, 1};

    assign req_ready[0][3:2] = 2'b00;
    assign rsp_valid[0][3:2] = 2'b00;

    alu_arbiter #(.N_REQ(2), .TRACE(0)) u_dut2 (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (req_valid[0][1:0]),
        .o_req_ready     (req_ready[0][1:0]),
        .i_req_instr     (req_instr[0][63:0]),
        .i_req_op1       (req_op1[0][63:0]),
        .i_req_op2       (req_op2[0][63:0]),
        .o_rsp_valid     (rsp_valid[0][1:0]),
        .i_rsp_ready     (rsp_ready[0][1:0]),
        .o_rsp_result    (rsp_result[0]),
        .o_rsp_illegal   (rsp_illegal[0]),
`ifdef ALU_ARB_STATS_EN
        .o_grant_count   (gc0),
        .o_illegal_count (ic0),
`endif
        .o_alu_enable    (alu_enable[0]),
        .o_alu_instr     (alu_instr[0]),
        .o_alu_op1       (alu_op1[0]),
        .o_alu_op2       (alu_op2[0]),
        .i_alu_instr_exec(alu_exec[0]),
        .i_alu_result    (alu_res[0])
    );

    alu_arbiter #(.N_REQ(4), .TRACE(0)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (req_valid[1]),
        .o_req_ready     (req_ready[1]),
        .i_req_instr     (req_instr[1]),
        .i_req_op1       (req_op1[1]),
        .i_req_op2       (req_op2[1]),
        .o_rsp_valid     (rsp_valid[1]),
        .i_rsp_ready     (rsp_ready[1]),
        .o_rsp_result    (rsp_result[1]),
        .o_rsp_illegal   (rsp_illegal[1]),
`ifdef ALU_ARB_STATS_EN
        .o_grant_count   (gc1),
        .o_illegal_count (ic1),
`endif
        .o_alu_enable    (alu_enable[1]),
        .o_alu_instr     (alu_instr[1]),
        .o_alu_op1       (alu_op1[1]),
        .o_alu_op2       (alu_op2[1]),
        .i_alu_instr_exec(alu_exec[1]),
        .i_alu_result    (alu_res[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {legal, result}
    function automatic logic [32:0] alu_fn(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
        case (ins)
            OP_ADD:  return {1'b1, a + b};
            OP_SUB:  return {1'b1, a - b};
            32'h3:   return {1'b1, a ^ b};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    // Stand-in ALU: one-cycle latency, holds outputs when not enabled.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                alu_res[n]  <= '0;
                alu_exec[n] <= 1'b0;
            end else if (alu_enable[n]) begin
                if (alu_fn(alu_instr[n], alu_op1[n], alu_op2[n]) >> 32 != 0) begin
                    alu_res[n] <= alu_fn(alu_instr[n], alu_op1[n], alu_op2[n]) & 33'hFFFF_FFFF;
                end
                alu_exec[n] <= alu_fn(alu_instr[n], alu_op1[n], alu_op2[n]) >> 32 != 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_op(input int n, input int i, input logic [31:0] ins,
                          input logic [31:0] a, input logic [31:0] b);
        req_instr[n][32*i +: 32] = ins;
        req_op1[n][32*i +: 32]   = a;
        req_op2[n][32*i +: 32]   = b;
    endtask

    // One clock: compare both instances against the model at the falling
    // edge, advance the model, then return just after the rising edge.
    task automatic tick();
        int          nn;
        int          w;
        int          idx;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_rv;
        logic [32:0] f;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            nn = (n == 0) ? 2 : 4;
            w  = -1;
            if (!m_pend[n] || rsp_ready[n][m_pidx[n]]) begin
                for (int k = 0; k < nn; k++) begin
                    idx = (m_ptr[n] + k) % nn;
                    if (w < 0 && req_valid[n][idx]) w = idx;
                end
            end
            exp_rdy = (w >= 0) ? (4'b1 << w) : 4'b0;
            chk($sformatf("inst%0d req_ready", n), {28'b0, req_ready[n]}, {28'b0, exp_rdy});
            chk($sformatf("inst%0d alu_enable", n), {31'b0, alu_enable[n]}, {31'b0, w >= 0});
            if (w >= 0) begin
                chk($sformatf("inst%0d alu_instr", n), alu_instr[n], req_instr[n][32*w +: 32]);
                chk($sformatf("inst%0d alu_op1", n), alu_op1[n], req_op1[n][32*w +: 32]);
                chk($sformatf("inst%0d alu_op2", n), alu_op2[n], req_op2[n][32*w +: 32]);
            end else begin
                chk($sformatf("inst%0d alu_instr idle", n), alu_instr[n], 32'h0);
            end
            exp_rv = m_pend[n] ? (4'b1 << m_pidx[n]) : 4'b0;
            chk($sformatf("inst%0d rsp_valid", n), {28'b0, rsp_valid[n]}, {28'b0, exp_rv});
            if (m_pend[n]) begin
                chk($sformatf("inst%0d rsp_result", n), rsp_result[n], m_res[n]);
                chk($sformatf("inst%0d rsp_illegal", n), {31'b0, rsp_illegal[n]},
                    {31'b0, m_ill[n]});
            end else begin
                chk($sformatf("inst%0d rsp_illegal idle", n), {31'b0, rsp_illegal[n]}, 32'h0);
            end
            for (int k = 0; k < 4; k++) begin
                if (req_ready[n][k]) begin
                    if (n == 0) glog0.push_back(k);
                    else        glog1.push_back(k);
                end
            end
            if (rst) begin
                m_ptr[n]  = 0;
                m_pend[n] = 0;
                m_pidx[n] = 0;
                m_last[n] = '0;
            end else if (w >= 0) begin
                m_ptr[n]  = (w + 1) % nn;
                m_pend[n] = 1;
                m_pidx[n] = w;
                f = alu_fn(req_instr[n][32*w +: 32], req_op1[n][32*w +: 32],
                           req_op2[n][32*w +: 32]);
                if (f[32]) m_last[n] = f[31:0];
                m_res[n] = m_last[n];
                m_ill[n] = !f[32];
            end else if (m_pend[n] && rsp_ready[n][m_pidx[n]]) begin
                m_pend[n] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            req_valid[n] = '0;
            rsp_ready[n] = '0;
            req_instr[n] = '0;
            req_op1[n]   = '0;
            req_op2[n]   = '0;
            m_ptr[n]     = 0;
            m_pend[n]    = 0;
            m_pidx[n]    = 0;
            m_last[n]    = '0;
            m_res[n]     = '0;
            m_ill[n]     = 0;
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int n = 0; n < 2; n++) begin
            chk("reset rsp_valid", {28'b0, rsp_valid[n]}, 32'h0);
            chk("reset req_ready", {28'b0, req_ready[n]}, 32'h0);
            chk("reset alu_enable", {31'b0, alu_enable[n]}, 32'h0);
            chk("reset rsp_illegal", {31'b0, rsp_illegal[n]}, 32'h0);
        end

        // 1: two requesters alternate, results 8 and 17
        set_op(0, 0, OP_ADD, 5, 3);
        set_op(0, 1, OP_ADD, 10, 7);
        req_valid[0] = 4'b0011;
        rsp_ready[0] = 4'b0011;
        glog0.delete();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t1 rsp_valid", {28'b0, rsp_valid[0]}, (c % 2 == 0) ? 32'h1 : 32'h2);
            chk("t1 rsp_result", rsp_result[0], (c % 2 == 0) ? 32'd8 : 32'd17);
        end
        req_valid[0] = '0;
        tick();
        chk("t1 grant count", glog0.size(), 4);
        for (int i = 0; i < 4 && i < glog0.size(); i++) chk("t1 grant order", glog0[i], exp2[i]);

        // 2: backpressure holds the response and blocks new grants
        set_op(0, 0, OP_SUB, 3, 5);
        req_valid[0] = 4'b0001;
        rsp_ready[0] = 4'b0000;
        tick();
        set_op(0, 0, OP_ADD, 1, 1);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("t2 hold rsp_valid", {28'b0, rsp_valid[0]}, 32'h1);
            chk("t2 hold rsp_result", rsp_result[0], 32'hFFFF_FFFE);
            chk("t2 hold req_ready", {28'b0, req_ready[0]}, 32'h0);
            chk("t2 hold alu_enable", {31'b0, alu_enable[0]}, 32'h0);
            tick();
        end
        rsp_ready[0] = 4'b0001;
        #1;
        chk("t2 accept grant", {28'b0, req_ready[0]}, 32'h1);
        chk("t2 accept alu_enable", {31'b0, alu_enable[0]}, 32'h1);
        tick();
        chk("t2 next result", rsp_result[0], 32'd2);
        req_valid[0] = '0;
        tick();

        // 3: illegal opcode reports stale result
        rsp_ready[0] = 4'b0011;
        set_op(0, 1, OP_ADD, 40, 2);
        req_valid[0] = 4'b0010;
        tick();
        chk("t3 add result", rsp_result[0], 32'd42);
        set_op(0, 1, OP_BAD, 9, 9);
        tick();
        chk("t3 rsp_valid", {28'b0, rsp_valid[0]}, 32'h2);
        chk("t3 rsp_illegal", {31'b0, rsp_illegal[0]}, 32'h1);
        chk("t3 stale result", rsp_result[0], 32'd42);
        req_valid[0] = '0;
        tick();

        // 4: four requesters, full throughput, then one drops out
        for (int i = 0; i < 4; i++) set_op(1, i, OP_ADD, i, 100);
        req_valid[1] = 4'b1111;
        rsp_ready[1] = 4'b1111;
        glog1.delete();
        for (int c = 0; c < 8; c++) tick();
        req_valid[1] = 4'b1011;
        for (int c = 0; c < 4; c++) tick();
        req_valid[1] = '0;
        tick();
        chk("t4 grant count", glog1.size(), 12);
        for (int i = 0; i < 12 && i < glog1.size(); i++) chk("t4 grant order", glog1[i], exp4[i]);

        // 5: reset while a response is stalled
        set_op(0, 0, OP_ADD, 1, 2);
        req_valid[0] = 4'b0001;
        rsp_ready[0] = 4'b0000;
        tick();
        req_valid[0] = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5 rsp_valid", {28'b0, rsp_valid[0]}, 32'h0);
        chk("t5 req_ready", {28'b0, req_ready[0]}, 32'h0);
        set_op(0, 1, OP_ADD, 4, 4);
        req_valid[0] = 4'b0011;
        rsp_ready[0] = 4'b0011;
        #1;
        chk("t5 first grant", {28'b0, req_ready[0]}, 32'h1);
        tick();
        req_valid[0] = '0;
        tick();

`ifdef ALU_ARB_STATS_EN
        // 6: statistics counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 0, OP_ADD, 1, 1);
        set_op(0, 1, OP_ADD, 2, 2);
        rsp_ready[0] = 4'b0011;
        req_valid[0] = 4'b0001;
        for (int c = 0; c < 5; c++) tick();
        req_valid[0] = 4'b0010;
        for (int c = 0; c < 2; c++) tick();
        set_op(0, 1, OP_BAD, 0, 0);
        tick();
        req_valid[0] = '0;
        tick();
        chk("t6 grant_count", gc0, {16'd3, 16'd5});
        chk("t6 illegal_count", {16'b0, ic0}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter that shares one single-cycle-latency alu instance among N_REQ requesters, such as issue slots or harts.
Each requester presents instr/op1/op2 with a valid/ready handshake and gets back its result, plus an illegal flag, on a per-requester response channel.
Sits between decode/operand-fetch and the alu; drives alu enable/instr/op1/op2 and consumes alu result/instr_exec.

Parameters:
N_REQ, 2, number of requesters (2..8); index width IW = $clog2(N_REQ), minimum 1.
TRACE, 0, nonzero: $display each grant (requester index, decode_instr) under `ifndef SYNTHESIS.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  N_REQ  requester i has an op
req_ready  output  N_REQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
req_instr  input  N_REQ*32  instruction_t per requester, slice i = [32*i +: 32]
req_op1  input  N_REQ*32  register_t operand 1 per requester
req_op2  input  N_REQ*32  register_t operand 2 per requester
rsp_valid  output  N_REQ  response for requester i pending (at most one bit set)
rsp_ready  input  N_REQ  requester i accepts its response
rsp_result  output  32  result of pending response (shared bus)
rsp_illegal  output  1  pending op was not an alu opcode (alu instr_exec==0)
alu_enable  output  1  to alu enable
alu_instr  output  32  to alu instr
alu_op1  output  32  to alu op1
alu_op2  output  32  to alu op2
alu_instr_exec  input  1  from alu instr_exec
alu_result  input  32  from alu result

Behaviour:
- State: rr_ptr (IW bits), pend_valid (1), pend_idx (IW).
- Reset: rr_ptr=0, pend_valid=0, pend_idx=0. Outputs: req_ready=0, rsp_valid=0, alu_enable=0, rsp_illegal=0. rsp_result follows alu_result (0 after alu reset).
- slot_free = !pend_valid || rsp_ready[pend_idx].
- Grant is combinational:
  - if slot_free and any req_valid, pick first set req_valid scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready = one-hot of winner; alu_enable=1; alu_instr/op1/op2 = winner's slices.
  - otherwise req_ready=0, alu_enable=0, alu_* = 0.
- req_ready depends only on req_valid, state and rsp_ready. Never assert req_ready[i] when req_valid[i]=0.
- On grant edge: rr_ptr <= (winner+1) mod N_REQ; pend_valid<=1; pend_idx<=winner.
- With no grant: rr_ptr holds; pend_valid <= pend_valid && !rsp_ready[pend_idx].
- Latency: grant in cycle T, so rsp_valid[winner]=1 in cycle T+1 with rsp_result=alu_result and rsp_illegal=!alu_instr_exec.
- rsp_valid = pend_valid ? onehot(pend_idx) : 0.
- Backpressure: the response holds while rsp_ready[pend_idx]=0. alu_enable is 0 during the hold, so the alu keeps result and instr_exec stable. No new grant while stalled.
- Throughput: 1 op/cycle when responses are accepted same cycle (accept and new grant in the same cycle allowed).
- rsp_ready bits of non-pending requesters are ignored.
- Illegal opcode: the alu holds its prior result, so rsp_result is stale. Consumers must honour rsp_illegal.
- rsp_illegal = 0 when pend_valid=0. alu_instr_exec is ignored when pend_valid=0 (the alu does not reset it).
- Reset mid-operation: pending response dropped, rr_ptr=0. Requesters reissue.
- req_valid dropped before grant: permitted, no side effect.

Optional Feature:
ALU_ARB_STATS_EN
- Defined: adds output grant_count (N_REQ*16).
  - Per-requester 16-bit counter, +1 on each grant to i.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
  - Adds output illegal_count (16): +1 on each accepted response with rsp_illegal=1, saturating.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, N_REQ=2, req_valid=2'b11 both ADD (5+3, 10+7) held -> grants alternate 0,1,0,1. rsp_valid one cycle after each grant; results 8, 17; rr_ptr starts at 0.
2. Req0 only, SUB 3-5, rsp_ready[0]=0 for 3 cycles -> rsp_result=32'hFFFFFFFE held; rsp_valid[0] held; req_ready=0 and alu_enable=0 until accepted; next grant same cycle as accept.
3. Req1 issues a non-alu opcode after a prior ADD result 42 -> rsp_valid[1]=1, rsp_illegal=1, rsp_result=42.
4. N_REQ=4, all valid, responses always accepted -> grant order 0,1,2,3,0 at 1 op/cycle. Drop req_valid[2] -> order 0,1,3,0.
5. Assert rst in the cycle after a grant with rsp_ready=0 -> next cycle rsp_valid=0, req_ready=0, rr_ptr=0; first post-reset grant goes to requester 0.
6. ALU_ARB_STATS_EN: 5 grants to req0, 3 to req1, one illegal -> grant_count = {16'd3,16'd5}, illegal_count=1.
